// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl_if
// Brief    : Command/response handshake and SPI pin bundle for spi_master_ctrl.
// Revision : 1.0
// ============================================================================
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       ss_n;
    logic       MOSI;
    logic       MISO;
    logic       valid_MISO;
    logic       sready;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO, valid_MISO, sready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ss_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO, valid_MISO, sready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ss_n, MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : SPI master that frames 2-bit op + 8-bit payload as 11 bits and
//            collects the 8-bit reply for read-data commands.
// Revision : 1.0
// ============================================================================
module spi_master_ctrl #(
    parameter int TIMEOUT    = 32,
    parameter int GAP_CYCLES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    spi_master_ctrl_if.master bus
);
    localparam int               TO_W     = $clog2(TIMEOUT + 1);
    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'd10;
    localparam logic [3:0]       RX_LAST  = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_READY = 3'd1,
        S_SHIFT      = 3'd2,
        S_RX         = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [10:0]      shift_q,     shift_d;
    logic             is_rd_q,     is_rd_d;
    logic [3:0]       bit_cnt_q,   bit_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic [6:0]       rx_q,        rx_d;
    logic             ss_n_q,      ss_n_d;
    logic             mosi_q,      mosi_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q,  rsp_data_d;
    logic             rsp_err_q,   rsp_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            is_rd_q     <= 1'b0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            rx_q        <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            is_rd_q     <= is_rd_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rx_q        <= rx_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        is_rd_d     = is_rd_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rx_d        = rx_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    // Bit 10 duplicates op[1] as the slave's wr/rd select.
                    shift_d = {bus.cmd_op[1], bus.cmd_op, bus.cmd_data};
                    is_rd_d = &bus.cmd_op;
                    state_d = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (bus.sready) begin
                    ss_n_d  = 1'b0;
                    mosi_d  = shift_q[10];
                    shift_d = {shift_q[9:0], 1'b0};
                    state_d = S_SHIFT;
                end else if (to_cnt_q == TO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    mosi_d = 1'b0;
                    if (is_rd_q) begin
                        state_d = S_RX;
                    end else begin
                        ss_n_d      = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_GAP;
                    end
                end else begin
                    mosi_d    = shift_q[10];
                    shift_d   = {shift_q[9:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_RX: begin
                if (bus.valid_MISO) begin
                    rx_d      = {rx_q[5:0], bus.MISO};
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == RX_LAST) begin
                        ss_n_d      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {rx_q, bus.MISO};
                        state_d     = S_GAP;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    ss_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Every state starts with fresh counters.
        if (state_d != state_q) begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            gap_cnt_d = '0;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ss_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Brief    : Self-checking bench for spi_master_ctrl with an in-bench SPI slave.
// Revision : 1.0
// ============================================================================
module tb_spi_master_ctrl;
    localparam int TIMEOUT    = 32;
    localparam int GAP_CYCLES = 2;
    localparam int MAX_CYC    = 400;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        int         rdy;
        logic [7:0] reply;
        int         nbits;
        int         gap;
        bit         noise;
        logic       exp_err;
        logic [7:0] exp_data;
        int         exp_low;
    } vec_t;

    typedef struct {
        int          n_rsp;
        logic        err;
        logic [7:0]  data;
        int          low;
        int          last_low;
        int          rsp_cyc;
        logic        rsp_ssn;
        int          gap_len;
        int          bad_ready;
        int          bad_idle;
        logic [10:0] frame;
        int          tail_ones;
        bit          hung;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(
        .TIMEOUT   (TIMEOUT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: outcome and ss_n-low duration from the protocol rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.rdy >= TIMEOUT) begin
            r.exp_err = 1'b1; r.exp_data = 8'h00; r.exp_low = 0;
        end else if (v.op != 2'b11) begin
            r.exp_err = 1'b0; r.exp_data = 8'h00; r.exp_low = 11;
        end else if (v.nbits >= 8) begin
            r.exp_err = 1'b0; r.exp_data = v.reply; r.exp_low = 11 + 7 * (v.gap + 1) + 1;
        end else begin
            r.exp_err  = 1'b1;
            r.exp_data = 8'h00;
            r.exp_low  = 11 + TIMEOUT + ((v.nbits == 0) ? 0 : (v.nbits - 1) * (v.gap + 1) + 1);
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, output obs_t o);
        int  j;
        int  r;
        int  idx;
        int  w;
        bit  done;
        o = '{default: 0};
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_data  = v.data;
        bus.sready    = 1'b0;
        j    = 0;
        done = 1'b0;
        while (!done && j < MAX_CYC) begin
            tick();
            j++;
            bus.cmd_valid = 1'b0;
            if (bus.cmd_ready === bus.busy) o.bad_ready++;
            if (bus.rsp_valid !== 1'b1 && (bus.rsp_err !== 1'b0 || bus.rsp_data !== 8'h00)) o.bad_idle++;
            if (bus.ss_n === 1'b0) begin
                o.low++;
                o.last_low = j;
                if (o.low <= 11) o.frame = {o.frame[9:0], bus.MOSI};
                else if (bus.MOSI !== 1'b0) o.tail_ones++;
            end
            if (bus.rsp_valid === 1'b1) begin
                o.n_rsp++;
                o.err     = bus.rsp_err;
                o.data    = bus.rsp_data;
                o.rsp_cyc = j;
                o.rsp_ssn = bus.ss_n;
            end
            if (o.n_rsp > 0 && bus.busy === 1'b1) o.gap_len++;
            if (o.n_rsp > 0 && bus.cmd_ready === 1'b1) done = 1'b1;
            // Slave behaviour for the next edge.
            bus.sready = (j > v.rdy);
            if (bus.ss_n === 1'b0 && o.low >= 12) begin
                r   = o.low - 12;
                idx = r / (v.gap + 1);
                bus.valid_MISO = (r % (v.gap + 1) == 0) && (idx < v.nbits);
                bus.MISO       = (idx < 8) ? v.reply[3'(7 - idx)] : 1'b0;
            end else begin
                bus.valid_MISO = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.MISO       = 1'($urandom_range(0, 1));
            end
        end
        o.hung         = !done;
        bus.sready     = 1'b0;
        bus.valid_MISO = 1'b0;
        bus.MISO       = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        obs_t        o;
        int          sel;
        int          accepts;
        int          nrsp;
        int          phase;
        int          hi_run;
        int          rdy_in_f1;
        int          lowc;
        int          stray;
        logic        prev_ready;
        logic [10:0] frame2;

        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_data   = 8'h00;
        bus.MISO       = 1'b0;
        bus.valid_MISO = 1'b0;
        bus.sready     = 1'b0;
        repeat (3) tick();
        check("rst_ss_n",      int'(bus.ss_n),      1);
        check("rst_mosi",      int'(bus.MOSI),      0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_data",  int'(bus.rsp_data),  0);
        check("rst_rsp_err",   int'(bus.rsp_err),   0);
        check("rst_busy",      int'(bus.busy),      0);
        rst = 1'b0;
        tick();
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);

        // op, data, rdy, reply, nbits, gap, noise, exp_err, exp_data, exp_low
        vecs.push_back('{2'b00, 8'h3C,  0, 8'h00, 0, 0, 1'b0, 1'b0, 8'h00, 11});
        vecs.push_back('{2'b11, 8'h00,  0, 8'hA5, 8, 1, 1'b0, 1'b0, 8'hA5, 26});
        vecs.push_back('{2'b01, 8'h5A, 10, 8'h00, 0, 0, 1'b0, 1'b0, 8'h00, 11});
        vecs.push_back('{2'b10, 8'h81, 32, 8'h00, 0, 0, 1'b0, 1'b1, 8'h00,  0});
        vecs.push_back('{2'b11, 8'h00,  0, 8'h5A, 5, 0, 1'b0, 1'b1, 8'h00, 48});
        vecs.push_back('{2'b11, 8'h00, 31, 8'hFF, 8, 0, 1'b0, 1'b0, 8'hFF, 19});
        vecs.push_back('{2'b11, 8'h00,  0, 8'h00, 0, 0, 1'b0, 1'b1, 8'h00, 43});
        vecs.push_back('{2'b00, 8'hFF,  0, 8'h00, 0, 0, 1'b1, 1'b0, 8'h00, 11});
        vecs.push_back('{2'b11, 8'h33,  3, 8'h3C, 8, 3, 1'b1, 1'b0, 8'h3C, 40});
        vecs.push_back('{2'b11, 8'h00, 33, 8'h77, 8, 0, 1'b0, 1'b1, 8'h00,  0});

        for (int k = 0; k < 16; k++) begin
            v       = '{default: 0};
            v.op    = 2'($urandom_range(0, 3));
            v.data  = 8'($urandom);
            sel     = int'($urandom_range(0, 9));
            v.rdy   = (sel < 7) ? int'($urandom_range(0, 4)) :
                      (sel == 7) ? TIMEOUT - 1 : (sel == 8) ? TIMEOUT : int'($urandom_range(33, 40));
            v.reply = 8'($urandom);
            v.nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8;
            v.gap   = int'($urandom_range(0, 3));
            v.noise = 1'($urandom_range(0, 1));
            vecs.push_back(model(v));
        end

        foreach (vecs[i]) begin
            v = vecs[i];
            run_vec(v, o);
            check($sformatf("v%0d_hung", i),      int'(o.hung),      0);
            check($sformatf("v%0d_rsp_count", i), o.n_rsp,           1);
            check($sformatf("v%0d_rsp_err", i),   int'(o.err),       int'(v.exp_err));
            check($sformatf("v%0d_rsp_data", i),  int'(o.data),      int'(v.exp_data));
            check($sformatf("v%0d_ss_low", i),    o.low,             v.exp_low);
            check($sformatf("v%0d_rsp_ss_n", i),  int'(o.rsp_ssn),   1);
            check($sformatf("v%0d_gap_len", i),   o.gap_len,         GAP_CYCLES);
            check($sformatf("v%0d_ready_busy", i), o.bad_ready,      0);
            check($sformatf("v%0d_idle_rsp", i),  o.bad_idle,        0);
            check($sformatf("v%0d_rx_mosi", i),   o.tail_ones,       0);
            if (v.exp_low > 0) begin
                check($sformatf("v%0d_frame", i), int'(o.frame), int'({v.op[1], v.op, v.data}));
                check($sformatf("v%0d_rsp_at_rise", i), o.rsp_cyc, o.last_low + 1);
            end
        end

        // Back-to-back: cmd_valid held across two commands.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_data  = 8'h11;
        bus.sready    = 1'b1;
        accepts = 0; nrsp = 0; phase = 0; hi_run = 0; rdy_in_f1 = 0; frame2 = '0;
        prev_ready = bus.cmd_ready;
        for (int j = 0; j < MAX_CYC && !(accepts == 2 && nrsp == 2 && bus.cmd_ready === 1'b1); j++) begin
            tick();
            if (prev_ready === 1'b1 && bus.cmd_valid === 1'b1) accepts++;
            if (accepts == 1) begin
                bus.cmd_op   = 2'b00;
                bus.cmd_data = 8'h22;
            end
            if (accepts == 2) bus.cmd_valid = 1'b0;
            if (accepts == 1 && phase < 2 && bus.cmd_ready === 1'b1) rdy_in_f1++;
            case (phase)
                0: if (bus.ss_n === 1'b0) phase = 1;
                1: if (bus.ss_n === 1'b1) begin phase = 2; hi_run = 1; end
                2: if (bus.ss_n === 1'b0) begin phase = 3; frame2 = {frame2[9:0], bus.MOSI}; end
                   else hi_run++;
                default: if (bus.ss_n === 1'b0) frame2 = {frame2[9:0], bus.MOSI};
            endcase
            if (bus.rsp_valid === 1'b1) nrsp++;
            prev_ready = bus.cmd_ready;
        end
        bus.cmd_valid = 1'b0;
        bus.sready    = 1'b0;
        check("b2b_accepts",      accepts,   2);
        check("b2b_rsp_count",    nrsp,      2);
        check("b2b_ready_in_f1",  rdy_in_f1, 0);
        check("b2b_gap_ge_min",   int'(hi_run >= GAP_CYCLES + 1), 1);
        check("b2b_frame2",       int'(frame2), int'(11'h022));

        // Reset while bit 5 of the frame is on MOSI.
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'hFF;
        bus.sready    = 1'b1;
        lowc = 0;
        for (int j = 0; j < 60 && lowc < 6; j++) begin
            tick();
            bus.cmd_valid = 1'b0;
            if (bus.ss_n === 1'b0) lowc++;
        end
        check("rstmid_reached",   lowc,            6);
        check("rstmid_mosi_pre",  int'(bus.MOSI),  1);
        rst = 1'b1;
        tick();
        check("rstmid_ss_n",      int'(bus.ss_n),      1);
        check("rstmid_mosi",      int'(bus.MOSI),      0);
        check("rstmid_rsp_valid", int'(bus.rsp_valid), 0);
        rst = 1'b0;
        tick();
        check("rstmid_cmd_ready", int'(bus.cmd_ready), 1);
        bus.sready = 1'b0;
        stray = 0;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.ss_n !== 1'b1) stray++;
        end
        check("rstmid_quiet", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Host-side SPI master that drives one SPI_Slave (FSM + RAM) instance over ss_n/MOSI and collects read data from MISO/valid_MISO.
- Accepts one command at a time (2-bit opcode + 8-bit payload) on a valid/ready handshake and serialises it as an 11-bit frame.
- For read-data commands (op=2'b11), it captures the 8-bit reply and returns it on a one-cycle response strobe.
- Sits directly upstream of the slave, in the same clock domain, one clk per SPI bit.

Parameters:
- TIMEOUT, 32: cycles allowed waiting for sready high, or between consecutive valid_MISO bits, before aborting with rsp_err.
- GAP_CYCLES, 2: minimum cycles ss_n is held high after every frame (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE (combinational from state).
- cmd_op  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- cmd_data  in  8  payload (address or data; don't-care for op=11).
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_data  out  8  read byte (op=11), else 0.
- rsp_err  out  1  qualifies rsp_valid: timeout abort.
- busy  out  1  state != IDLE.
- ss_n  out  1  slave select, active-low, registered.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave.
- valid_MISO  in  1  MISO bit valid this cycle.
- sready  in  1  slave ready for a new frame.

Behaviour:
- **Reset (rst=1 at an edge):**
  - State goes to IDLE; ss_n=1, MOSI=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - All counters clear; cmd_ready=1 from the first cycle after rst is released.
  - rst mid-frame: ss_n=1 at that edge, no rsp_valid is issued, and the captured command is discarded.
- **Command capture:** on cmd_valid&&cmd_ready, latch shift_reg = {cmd_op[1], cmd_op, cmd_data} (11 bits); bit 10 is the slave's wr/rd select. Go to WAIT_READY.
- **WAIT_READY:**
  - ss_n=1.
  - If sready=1: go to SHIFT; ss_n=0 and MOSI=shift_reg[10] at the same edge.
  - If sready has stayed 0 for TIMEOUT cycles: rsp_valid=1, rsp_err=1, rsp_data=0; go to GAP. No frame is started.
- **SHIFT:**
  - MSB first, one bit per edge, bit counter 0..10; ss_n stays 0.
  - After bit 0 has been driven for one cycle:
    - op!=11: ss_n=1, MOSI=0, rsp_valid=1, rsp_err=0, rsp_data=0; go to GAP. ss_n is low for exactly 11 cycles.
    - op=11: go to RX.
- **RX:**
  - ss_n=0, MOSI=0.
  - Each cycle with valid_MISO=1 shifts MISO into rx_reg (MSB first) and reloads the timeout counter.
  - After the 8th valid bit: at the next edge ss_n=1, rsp_valid=1, rsp_data=rx_reg, rsp_err=0; go to GAP.
  - If TIMEOUT cycles pass with no valid_MISO: same exit with rsp_err=1, rsp_data=0.
  - valid_MISO outside RX is ignored.
- **GAP:** ss_n=1 for GAP_CYCLES cycles, then IDLE. rsp_valid is high only on the first GAP cycle.
- **Other rules:**
  - cmd_valid asserted while busy is not accepted; the host holds it.
  - Back-to-back commands are separated by at least GAP_CYCLES+1 cycles of ss_n high.
  - Counters are saturating-free: the bit counter is 4 bits and the timeout counter is $clog2(TIMEOUT+1) bits, both cleared on every state entry.

Test Plan:
- **Write address:** reset, then cmd op=00, data=0x3C, sready=1 → ss_n low 11 cycles; MOSI sequence 0,0,0,0,0,1,1,1,1,0,0; then one rsp_valid pulse with err=0, data=0x00.
- **Read data:** cmd op=11, data=0x00; slave model returns 0xA5 on valid_MISO with 1-cycle gaps between bits → MOSI first bits 1,1,1; rsp_valid with data=0xA5, err=0; ss_n returns high the cycle after the 8th bit.
- **sready stall:** sready=0 for 10 cycles, then 1 → ss_n stays high those 10 cycles and the frame then proceeds normally. sready held 0 for 32 cycles → rsp_err=1, ss_n never falls.
- **Read timeout:** op=11 with a slave that sends only 5 bits → 32 idle cycles later rsp_valid=1, rsp_err=1, rsp_data=0, ss_n=1.
- **Back-to-back:** cmd_valid held high for two commands → second accepted only after GAP (ss_n high ≥2 cycles); cmd_ready=0 throughout the first frame.
- **Reset mid-frame:** rst asserted at bit 5 of SHIFT → ss_n=1, MOSI=0 at that edge, no rsp_valid, cmd_ready=1 the cycle after release.
